ppe_rr_sched: RTL and testbench
===============================

Name: ppe_rr_sched

Overview:
- Round-robin scheduler that sequences the 3-stage programmable priority encoder (PPE) pipeline.
- Snapshots the requester vector and issues it with the current priority pointer as P_enc.
- Waits the fixed PPE latency, then presents the winner on a valid/ready grant port.
- On grant acceptance, advances the pointer to winner+1, giving fair rotation over 512 requesters.

Parameters:
- N, 512, requester count; equals PPE width.
- PTR_W, 9, pointer/index width; equals log2(N).
- LAT, 3, PPE latency in cycles from issue cycle to registered o_value/valid.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  scheduling enable; low blocks new issues
- req  in  N  level requests, one bit per requester
- ptr_load  in  1  one-cycle strobe: overwrite pointer
- ptr_init  in  PTR_W  pointer value for ptr_load
- ppe_req  out  N  request vector to PPE Req
- ppe_p_enc  out  PTR_W  priority pointer to PPE P_enc
- ppe_value  in  PTR_W  PPE o_value
- ppe_value_inc  in  PTR_W  PPE o_value_inc
- ppe_valid  in  1  PPE valid
- gnt_valid  out  1  grant available
- gnt_id  out  PTR_W  granted requester index
- gnt_ready  in  1  consumer accepts grant
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, ptr=0, ppe_req=0, ppe_p_enc=0, gnt_valid=0, gnt_id=0, busy=0, wait_cnt=0. All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, GRANT.
- IDLE:
  - If en && |req: snap<=req, go ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - ppe_req=snap and ppe_p_enc=ptr during this cycle only; ppe_req=0 in all other states.
  - wait_cnt<=LAT-1; go WAIT.
- WAIT:
  - Decrement wait_cnt each cycle.
  - When wait_cnt==0, sample ppe_value, ppe_value_inc and ppe_valid. This is cycle t+LAT when ISSUE occupied cycle t.
  - ppe_valid=1: gnt_id<=ppe_value, nxt<=ppe_value_inc, gnt_valid<=1, go GRANT.
  - ppe_valid=0 (defensive; snapshot was nonzero): no grant, ptr unchanged, go IDLE.
- GRANT:
  - gnt_valid and gnt_id stay stable until gnt_ready.
  - On gnt_valid&&gnt_ready: gnt_valid<=0, ptr<=nxt, go IDLE.
  - Minimum grant-to-grant spacing is therefore LAT+3 cycles.
- Pointer arithmetic is modulo 2^PTR_W: winner 511 gives ptr 0. Pointer semantics follow the PPE: the search starts at index ptr, wraps to lower indices, and the lowest-index request is the fallback.
- Stale grants: req is only sampled in IDLE. A bit dropping after the snapshot may still be granted; consumers tolerate this. Requesters hold req until granted.
- ptr_load:
  - Takes effect in any state: ptr<=ptr_init.
  - Wins over a simultaneous accept update.
  - During ISSUE, the issued ppe_p_enc uses the pre-load value.
- en low: no effect on an operation already in ISSUE/WAIT/GRANT; only blocks the IDLE->ISSUE transition.
- Reset mid-operation: returns to reset values immediately. The PPE pipeline is flushed by the shared rst, so no stale PPE result is consumed afterwards.

Optional Feature:
- Macro: PPE_RR_SCHED_STATS_EN.
- When defined, adds output stat_grants[31:0] and output stat_drops[15:0], both reset to 0.
  - stat_grants increments on each accepted grant, saturating.
  - stat_drops increments on each WAIT sample with ppe_valid=0, saturating.
- When undefined, neither port nor its logic exists.

Decomposition:
- Shared package ppe_pkg holds:
  - constants PPE_N=512, PPE_PTR_W=9, PPE_LAT=3;
  - the FSM state enum typedef (IDLE, ISSUE, WAIT, GRANT).
- One natural sub-module: ppe_sat_cnt, a parameterised saturating counter used by the stats option.
- The PPE itself is not instantiated here; it connects at the next level up.

Test Plan:
- Reset, then req=bit5, ptr=0 -> ppe_p_enc=0 in the ISSUE cycle, gnt_id=5 at cycle ISSUE+LAT+1; accept -> ptr=6.
- req={3,10,400} held, gnt_ready=1 always -> grants 3, 10, 400, 3, each spaced LAT+3 cycles.
- req={0,511}, ptr_load ptr_init=511 -> grant 511, ptr wraps to 0, next grant 0.
- gnt_ready held low 20 cycles -> gnt_valid and gnt_id stable, no new ISSUE, ptr unchanged until accept.
- ptr_load=1 ptr_init=100 in the same cycle as an accept of winner 7 -> ptr=100; next grant is the lowest request >=100.
- rst asserted during WAIT -> all outputs 0 next cycle; no grant appears. With PPE_RR_SCHED_STATS_EN: ppe_valid forced 0 at sample -> stat_drops=1, stat_grants unchanged.

Source files
------------

// File: rtl/ppe_pkg.sv
// Shared constants and FSM state encoding for the PPE round-robin scheduler.
// Pure declarations: no logic, no latency, no flow control.
package ppe_pkg;

  localparam int PPE_N     = 512;
  localparam int PPE_PTR_W = 9;
  localparam int PPE_LAT   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GRANT
  } ppe_state_e;

endpackage

// File: rtl/ppe_sat_cnt.sv
// Saturating up-counter for scheduler statistics; exists only with PPE_RR_SCHED_STATS_EN.
// Latency: count visible one cycle after inc; no backpressure, holds at all-ones.
`ifdef PPE_RR_SCHED_STATS_EN
module ppe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/ppe_rr_sched.sv
// Round-robin scheduler driving the external PPE; grant appears LAT+1 cycles after issue.
// Grant held on valid/ready until accepted; optional counters under PPE_RR_SCHED_STATS_EN.
module ppe_rr_sched
  import ppe_pkg::*;
#(
  parameter int N     = PPE_N,
  parameter int PTR_W = PPE_PTR_W,
  parameter int LAT   = PPE_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             ptr_load,
  input  logic [PTR_W-1:0] ptr_init,
  output logic [N-1:0]     ppe_req,
  output logic [PTR_W-1:0] ppe_p_enc,
  input  logic [PTR_W-1:0] ppe_value,
  input  logic [PTR_W-1:0] ppe_value_inc,
  input  logic             ppe_valid,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_id,
  input  logic             gnt_ready,
  output logic             busy
`ifdef PPE_RR_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_grants,
  output logic [15:0]      stat_drops
`endif
);

  localparam int CNT_W = (LAT > 2) ? $clog2(LAT) : 1;

  ppe_state_e       state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [PTR_W-1:0] nxt, nxt_d;
  logic [CNT_W-1:0] wait_cnt, cnt_d;
  logic [N-1:0]     req_d;
  logic [PTR_W-1:0] penc_d;
  logic             gv_d;
  logic [PTR_W-1:0] gid_d;
  logic             busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      nxt       <= '0;
      wait_cnt  <= '0;
      ppe_req   <= '0;
      ppe_p_enc <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      nxt       <= nxt_d;
      wait_cnt  <= cnt_d;
      ppe_req   <= req_d;
      ppe_p_enc <= penc_d;
      gnt_valid <= gv_d;
      gnt_id    <= gid_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    nxt_d   = nxt;
    cnt_d   = wait_cnt;
    req_d   = '0;
    penc_d  = '0;
    gv_d    = gnt_valid;
    gid_d   = gnt_id;
    unique case (state)
      IDLE: begin
        // Snapshot is captured straight into the issue register so the PPE sees it next cycle.
        if (en && (|req)) begin
          req_d   = req;
          penc_d  = ptr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          if (ppe_valid) begin
            gid_d   = ppe_value;
            nxt_d   = ppe_value_inc;
            gv_d    = 1'b1;
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = wait_cnt - 1'b1;
        end
      end
      GRANT: begin
        if (gnt_valid && gnt_ready) begin
          gv_d    = 1'b0;
          ptr_d   = nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // An explicit load overrides the rotation update from an accept in the same cycle.
    if (ptr_load) begin
      ptr_d = ptr_init;
    end
    busy_d = (state_d != IDLE);
  end

`ifdef PPE_RR_SCHED_STATS_EN
  logic grant_acc;
  logic drop;

  assign grant_acc = (state == GRANT) && gnt_valid && gnt_ready;
  assign drop      = (state == WAIT) && (wait_cnt == '0) && !ppe_valid;

  ppe_sat_cnt #(.W(32)) u_grants (
    .clk (clk),
    .rst (rst),
    .inc (grant_acc),
    .cnt (stat_grants)
  );

  ppe_sat_cnt #(.W(16)) u_drops (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .cnt (stat_drops)
  );
`endif

endmodule

// File: tb/tb_ppe_rr_sched.sv
// Bench for ppe_rr_sched with a behavioural 3-stage PPE and a grant scoreboard.
// Expected grant ids are hand-derived constants pushed when stimulus is issued.
`timescale 1ns/1ps
module tb_ppe_rr_sched;
  import ppe_pkg::*;

  localparam int N   = PPE_N;
  localparam int W   = PPE_PTR_W;
  localparam int LAT = PPE_LAT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [N-1:0] req = '0;
  logic         ptr_load = 1'b0;
  logic [W-1:0] ptr_init = '0;
  logic [N-1:0] ppe_req;
  logic [W-1:0] ppe_p_enc;
  logic [W-1:0] ppe_value;
  logic [W-1:0] ppe_value_inc;
  logic         ppe_valid;
  logic         gnt_valid;
  logic [W-1:0] gnt_id;
  logic         gnt_ready = 1'b0;
  logic         busy;
  logic         kill = 1'b0;
`ifdef PPE_RR_SCHED_STATS_EN
  logic [31:0]  stat_grants;
  logic [15:0]  stat_drops;
`endif

  ppe_rr_sched dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .req           (req),
    .ptr_load      (ptr_load),
    .ptr_init      (ptr_init),
    .ppe_req       (ppe_req),
    .ppe_p_enc     (ppe_p_enc),
    .ppe_value     (ppe_value),
    .ppe_value_inc (ppe_value_inc),
    .ppe_valid     (ppe_valid),
    .gnt_valid     (gnt_valid),
    .gnt_id        (gnt_id),
    .gnt_ready     (gnt_ready),
    .busy          (busy)
`ifdef PPE_RR_SCHED_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_drops    (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment model of the PPE: search from p upward with wrap, registered over LAT stages.
  function automatic logic [W:0] ppe_f(input logic [N-1:0] r, input logic [W-1:0] p);
    logic [W-1:0] idx;
    for (int i = 0; i < N; i++) begin
      idx = p + W'(i);
      if (r[idx]) return {1'b1, idx};
    end
    return '0;
  endfunction

  logic [W:0] st1, st2, st3;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st1 <= '0; st2 <= '0; st3 <= '0;
    end else begin
      st1 <= ppe_f(ppe_req, ppe_p_enc);
      st2 <= st1;
      st3 <= st2;
    end
  end
  assign ppe_valid     = st3[W] && !kill;
  assign ppe_value     = st3[W-1:0];
  assign ppe_value_inc = st3[W-1:0] + 1'b1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int id;
    int gap;
  } exp_t;
  exp_t q[$];

  // Monitor: every accepted grant is popped and compared, with optional rise-to-rise spacing.
  initial begin
    exp_t e;
    int   rise = 0;
    int   last_rise = 0;
    logic prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (gnt_valid && !prev_v) rise = cyc;
      if (gnt_valid && gnt_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: got id=%0d want none", gnt_id);
        end else begin
          e = q.pop_front();
          chk("gnt_id", N'(gnt_id), N'(e.id));
          if (e.gap > 0) chk("gnt_gap", N'(rise - last_rise), N'(e.gap));
        end
        last_rise = rise;
      end
      prev_v = gnt_valid;
    end
  end

  task automatic wait_issue(output int c);
    c = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ppe_req != '0) begin c = cyc; break; end
    end
    if (c < 0) begin total++; bad++; $display("FAIL issue_timeout: got none want issue"); end
  endtask

  task automatic wait_gnt(output int c);
    c = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (gnt_valid) begin c = cyc; break; end
    end
    if (c < 0) begin total++; bad++; $display("FAIL grant_timeout: got none want grant"); end
  endtask

  task automatic drive_step();
    @(posedge clk); #1;
  endtask

  task automatic load_ptr(input int v);
    drive_step(); ptr_load = 1'b1; ptr_init = W'(v);
    drive_step(); ptr_load = 1'b0;
  endtask

  task automatic count_grants(input string name, input int want);
    int n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (gnt_valid && gnt_ready) n++;
      if (n == want) break;
    end
    chk(name, N'(n), N'(want));
    drive_step(); req = '0;
  endtask

  initial begin
    int ic, gc, seen;
    repeat (2) @(negedge clk);
    chk("rst_gnt_valid", N'(gnt_valid), '0);
    chk("rst_gnt_id", N'(gnt_id), '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_ppe_req", ppe_req, '0);
    chk("rst_ppe_p_enc", N'(ppe_p_enc), '0);
    drive_step(); rst = 1'b0; en = 1'b1;

    // Single request at bit 5 from ptr 0, then {5,7} from ptr 6.
    drive_step(); req = '0; req[5] = 1'b1; gnt_ready = 1'b1;
    q.push_back('{5, 0});
    wait_issue(ic);
    chk("t1_p_enc", N'(ppe_p_enc), '0);
    chk("t1_ppe_req", ppe_req, N'(32));
    chk("t1_busy", N'(busy), N'(1));
    wait_gnt(gc);
    chk("t1_latency", N'(gc - ic), N'(LAT + 1));
    drive_step(); req[7] = 1'b1;
    q.push_back('{7, 0});
    wait_issue(ic);
    chk("t1_ptr_after_accept", N'(ppe_p_enc), N'(6));
    wait_gnt(gc);
    drive_step(); req = '0;

    // Rotation over {3,10,400} with back-to-back acceptance.
    load_ptr(0);
    req[3] = 1'b1; req[10] = 1'b1; req[400] = 1'b1;
    q.push_back('{3, 0}); q.push_back('{10, LAT + 3});
    q.push_back('{400, LAT + 3}); q.push_back('{3, LAT + 3});
    count_grants("t2_count", 4);

    // Wrap from 511 back to 0.
    load_ptr(511);
    req[0] = 1'b1; req[511] = 1'b1;
    q.push_back('{511, 0}); q.push_back('{0, LAT + 3});
    wait_issue(ic);
    chk("t3_p_enc", N'(ppe_p_enc), N'(511));
    count_grants("t3_count", 2);

    // Stalled consumer: grant must hold and nothing new may issue.
    drive_step(); gnt_ready = 1'b0; req[20] = 1'b1;
    q.push_back('{20, 0});
    wait_gnt(gc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", N'(gnt_valid), N'(1));
      chk("t4_hold_id", N'(gnt_id), N'(20));
      chk("t4_no_issue", ppe_req, '0);
    end
    drive_step(); gnt_ready = 1'b1; req = '0; req[21] = 1'b1;
    q.push_back('{21, 0});
    wait_issue(ic);
    chk("t4_ptr", N'(ppe_p_enc), N'(21));
    wait_gnt(gc);
    drive_step(); req = '0;

    // ptr_load coincident with accept of winner 7 wins over winner+1.
    load_ptr(0);
    gnt_ready = 1'b0; req[7] = 1'b1; req[50] = 1'b1; req[120] = 1'b1;
    q.push_back('{7, 0});
    wait_gnt(gc);
    drive_step(); gnt_ready = 1'b1; ptr_load = 1'b1; ptr_init = W'(100);
    drive_step(); ptr_load = 1'b0;
    q.push_back('{120, 0});
    wait_issue(ic);
    chk("t5_p_enc", N'(ppe_p_enc), N'(100));
    wait_gnt(gc);
    drive_step(); req = '0;

    // Reset during WAIT drops the operation entirely.
    drive_step(); req[30] = 1'b1;
    wait_issue(ic);
    drive_step(); rst = 1'b1; req = '0;
    @(negedge clk);
    chk("t6_gnt_valid", N'(gnt_valid), '0);
    chk("t6_gnt_id", N'(gnt_id), '0);
    chk("t6_busy", N'(busy), '0);
    chk("t6_ppe_req", ppe_req, '0);
    chk("t6_ppe_p_enc", N'(ppe_p_enc), '0);
    drive_step(); rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt_valid || busy) seen++;
    end
    chk("t6_quiet_after_rst", N'(seen), '0);
    drive_step(); req[2] = 1'b1;
    q.push_back('{2, 0});
    wait_issue(ic);
    chk("t6_ptr_reset", N'(ppe_p_enc), '0);
    wait_gnt(gc);
    drive_step(); req = '0;

`ifdef PPE_RR_SCHED_STATS_EN
    @(negedge clk);
    chk("st_grants_1", N'(stat_grants), N'(1));
    chk("st_drops_0", N'(stat_drops), '0);
    drive_step(); kill = 1'b1; req[40] = 1'b1;
    wait_issue(ic);
    drive_step(); req = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("st_drop_idle", N'(busy), '0);
    chk("st_drops_1", N'(stat_drops), N'(1));
    chk("st_grants_same", N'(stat_grants), N'(1));
    drive_step(); kill = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", N'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
